hazard_ctrl_pipe: RTL and testbench
===================================

// Module: hazard_ctrl_pipe
// PURPOSE
//  Downstream end of the ID-stage control decoder. Carries the decoded control word
//  (RegDst/MemRead/MemWrite/MemToReg/AluSrc/RegWrite/ALUOp) and destination register
//  through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use hazards and drives
//  the decoder's bubble request Re. Freezes the pipe on data-memory wait, with a timeout.
// PARAMETERS
//  REG_ADDR_W    5   register-number width
//  ALUOP_W       2   ALUOp width
//  MEM_WAIT_MAX  15  max stalled cycles per memory access (>=1); CNT_W = $clog2(MEM_WAIT_MAX+1)
// PORTS
//  clk           in   1          single clock, rising edge
//  rst           in   1          synchronous, active-high reset
//  id_ctrl_*     in   1/ALUOP_W  decoder outputs: reg_dst,mem_read,mem_write,mem_to_reg,alu_src,reg_write,alu_op
//  id_rs,id_rt,id_rd in REG_ADDR_W  register fields of the instruction in ID
//  flush_id      in   1          branch taken: ID instruction is squashed; source holds it until pipe advances
//  mem_ready     in   1          data memory done with access in MEM stage
//  re            out  1          bubble request to decoder (Re)
//  pc_write      out  1          PC load enable
//  ifid_write    out  1          IF/ID register load enable
//  ex_*,mem_*,wb_* out 1/ALUOP_W registered control word per stage (all 7 fields in EX; mem_read,mem_write,
//                                mem_to_reg,reg_write in MEM; mem_to_reg,reg_write in WB)
//  ex_dst,mem_dst,wb_dst out REG_ADDR_W destination register per stage
//  mem_timeout   out  1          sticky: a memory access hit MEM_WAIT_MAX
// BEHAVIOUR
//  Reset: all stage regs, dst regs, mem_timeout, counter = 0; FSM = RUN. While rst=1: re=1, pc_write=0, ifid_write=0.
//  id_dst = id_ctrl_reg_dst ? id_rd : id_rt (X on reg_dst treated as 0).
//  Latency: ID word appears on ex_* 1 cycle later, mem_* 2, wb_* 3, when no stall.
//  mem_req   = mem_mem_read | mem_mem_write.
//  mem_stall = mem_req & ~mem_ready & ~(state==WAIT & cnt==MEM_WAIT_MAX).
//  load_use  = ex_mem_read & ex_dst!=0 & (ex_dst==id_rs | ex_dst==id_rt).
//  Priority per cycle (combinational outputs):
//   1 mem_stall: all three stage regs hold; pc_write=0; ifid_write=0; re=0; flush_id ignored.
//   2 load_use:  re=1; pc_write=0; ifid_write=0; ID/EX loads bubble (all-zero word, dst 0); EX/MEM, MEM/WB advance.
//   3 flush_id:  ID/EX loads bubble; pc_write=ifid_write=1; re=0.
//   4 else:      all advance; pc_write=ifid_write=1; re=0.
//  On a mem_stall cycle load_use/flush are re-evaluated once the pipe advances (inputs held upstream).
//  Memory-wait FSM {RUN, WAIT}:
//   RUN:  mem_req & ~mem_ready -> WAIT, cnt<=1 (this cycle stalled).
//   WAIT: mem_ready -> RUN, cnt<=0, pipe advances this cycle.
//         ~mem_ready & cnt==MEM_WAIT_MAX -> RUN, cnt<=0, pipe advances, mem_timeout<=1.
//         else cnt<=cnt+1 (stalled).
//   => an access never completing stalls exactly MEM_WAIT_MAX cycles, advances on the next.
//  mem_timeout clears only on rst. rst mid-stall: FSM->RUN, pipe emptied, no timeout flag.
//  MEM/WB only ever holds on mem_stall; no bubble is inserted past EX/MEM.
//  Register 0 never causes a hazard.
// STRUCTURE
//  Package pipeline_pkg: opcode constants (R-type 6'b000000, LW 6'b100011, SW 6'b101011),
//   ALUOp codes, ctrl-word struct/field offsets, FSM state encoding.
//  Sub-module ctrl_stage_reg: one pipeline stage register (width param, inputs hold, bubble,
//   sync rst); instantiated for ID/EX, EX/MEM, MEM/WB. Hazard compare and FSM stay in top.
// TESTING
//  1 rst=1 for 2 cycles -> all stage outputs 0, re=1, pc_write=0; rst release -> re=0, pc_write=1, ifid_write=1.
//  2 LW rt=8 in ID, next cycle ADD rs=8 in ID -> re=1, pc_write=0, ifid_write=0 for 1 cycle;
//    next cycle ex_* all 0, ex_dst=0; ADD reaches EX one cycle later with ex_reg_dst=1, ex_alu_op=2'b10.
//  3 LW rt=0 followed by ADD rs=0 -> no stall, re stays 0.
//  4 SW in MEM, mem_ready=0 for 3 cycles -> all stage regs hold 3 cycles, pc_write=0;
//    4th cycle mem_ready=1 -> pipe advances, mem_timeout=0.
//  5 LW in MEM, mem_ready held 0 -> exactly 15 stalled cycles, advance on 16th, mem_timeout=1 until rst.
//  6 flush_id=1 with R-type in ID -> ex_* all 0 next cycle; flush_id during mem stall ->
//    no effect until stall clears, then bubble enters ID/EX.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants and types for the ID/EX/MEM/WB control pipeline and its hazard logic.
package pipeline_pkg;

  localparam int DEF_REG_ADDR_W   = 5;
  localparam int DEF_ALUOP_W      = 2;
  localparam int DEF_MEM_WAIT_MAX = 15;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;

  typedef enum logic [DEF_ALUOP_W-1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10
  } aluop_t;

  // Bit order of the control word as carried through ID/EX (MSB first).
  typedef struct packed {
    logic                   reg_dst;
    logic                   mem_read;
    logic                   mem_write;
    logic                   mem_to_reg;
    logic                   alu_src;
    logic                   reg_write;
    logic [DEF_ALUOP_W-1:0] alu_op;
  } ctrl_word_t;

  localparam int CW_ALU_OP_LSB    = 0;
  localparam int CW_REG_WRITE     = DEF_ALUOP_W;
  localparam int CW_ALU_SRC       = DEF_ALUOP_W + 1;
  localparam int CW_MEM_TO_REG    = DEF_ALUOP_W + 2;
  localparam int CW_MEM_WRITE     = DEF_ALUOP_W + 3;
  localparam int CW_MEM_READ      = DEF_ALUOP_W + 4;
  localparam int CW_REG_DST       = DEF_ALUOP_W + 5;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

endpackage

// File: rtl/hazard_ctrl_pipe_if.sv
// Bundle between the ID-stage decoder / data memory and the hazard control pipeline.
interface hazard_ctrl_pipe_if
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int ALUOP_W    = DEF_ALUOP_W
);
  logic                  id_ctrl_reg_dst;
  logic                  id_ctrl_mem_read;
  logic                  id_ctrl_mem_write;
  logic                  id_ctrl_mem_to_reg;
  logic                  id_ctrl_alu_src;
  logic                  id_ctrl_reg_write;
  logic [ALUOP_W-1:0]    id_ctrl_alu_op;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  flush_id;
  logic                  mem_ready;

  logic                  re;
  logic                  pc_write;
  logic                  ifid_write;

  logic                  ex_reg_dst;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_mem_to_reg;
  logic                  ex_alu_src;
  logic                  ex_reg_write;
  logic [ALUOP_W-1:0]    ex_alu_op;
  logic [REG_ADDR_W-1:0] ex_dst;

  logic                  mem_mem_read;
  logic                  mem_mem_write;
  logic                  mem_mem_to_reg;
  logic                  mem_reg_write;
  logic [REG_ADDR_W-1:0] mem_dst;

  logic                  wb_mem_to_reg;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_dst;

  logic                  mem_timeout;

  modport master (
    output id_ctrl_reg_dst, id_ctrl_mem_read, id_ctrl_mem_write, id_ctrl_mem_to_reg,
           id_ctrl_alu_src, id_ctrl_reg_write, id_ctrl_alu_op, id_rs, id_rt, id_rd,
           flush_id, mem_ready,
    input  re, pc_write, ifid_write,
           ex_reg_dst, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_write,
           ex_alu_op, ex_dst, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write,
           mem_dst, wb_mem_to_reg, wb_reg_write, wb_dst, mem_timeout
  );

  modport slave (
    input  id_ctrl_reg_dst, id_ctrl_mem_read, id_ctrl_mem_write, id_ctrl_mem_to_reg,
           id_ctrl_alu_src, id_ctrl_reg_write, id_ctrl_alu_op, id_rs, id_rt, id_rd,
           flush_id, mem_ready,
    output re, pc_write, ifid_write,
           ex_reg_dst, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_write,
           ex_alu_op, ex_dst, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write,
           mem_dst, wb_mem_to_reg, wb_reg_write, wb_dst, mem_timeout
  );
endinterface

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: hold has priority over bubble, bubble loads all zeros.
module ctrl_stage_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         bubble,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (!hold)
      q <= bubble ? '0 : d;
  end

endmodule

// File: rtl/hazard_ctrl_pipe.sv
// Control-word pipeline ID/EX -> EX/MEM -> MEM/WB with load-use bubbling and a
// data-memory wait FSM that freezes the pipe for at most MEM_WAIT_MAX cycles per access.
module hazard_ctrl_pipe
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
  parameter int ALUOP_W      = DEF_ALUOP_W,
  parameter int MEM_WAIT_MAX = DEF_MEM_WAIT_MAX
) (
  input  logic               clk,
  input  logic               rst,
  hazard_ctrl_pipe_if.slave  bus
);

  localparam int CNT_W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_WAIT_MAX);
  localparam int EX_W  = 6 + ALUOP_W + REG_ADDR_W;
  localparam int MEM_W = 4 + REG_ADDR_W;
  localparam int WB_W  = 2 + REG_ADDR_W;

  logic [0:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic                  timeout_q;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  mem_req, at_limit, mem_stall, load_use;
  logic                  re_c, pcw_c, ifid_c, idex_bubble;
  logic [EX_W-1:0]       idex_d, idex_q;
  logic [MEM_W-1:0]      exmem_d, exmem_q;
  logic [WB_W-1:0]       memwb_d, memwb_q;

  // An unknown reg_dst falls to the else branch, selecting rt.
  always_comb begin
    id_dst = bus.id_rt;
    if (bus.id_ctrl_reg_dst)
      id_dst = bus.id_rd;
  end

  assign mem_req   = bus.mem_mem_read | bus.mem_mem_write;
  assign at_limit  = (state == ST_WAIT) && (cnt == CNT_MAX);
  assign mem_stall = mem_req & ~bus.mem_ready & ~at_limit;
  assign load_use  = bus.ex_mem_read && (bus.ex_dst != '0) &&
                     ((bus.ex_dst == bus.id_rs) || (bus.ex_dst == bus.id_rt));

  always_comb begin
    re_c        = 1'b0;
    pcw_c       = 1'b1;
    ifid_c      = 1'b1;
    idex_bubble = 1'b0;
    if (rst) begin
      re_c   = 1'b1;
      pcw_c  = 1'b0;
      ifid_c = 1'b0;
    end else if (mem_stall) begin
      pcw_c  = 1'b0;
      ifid_c = 1'b0;
    end else if (load_use) begin
      re_c        = 1'b1;
      pcw_c       = 1'b0;
      ifid_c      = 1'b0;
      idex_bubble = 1'b1;
    end else if (bus.flush_id) begin
      idex_bubble = 1'b1;
    end
  end

  assign bus.re         = re_c;
  assign bus.pc_write   = pcw_c;
  assign bus.ifid_write = ifid_c;

  assign idex_d  = {bus.id_ctrl_reg_dst, bus.id_ctrl_mem_read, bus.id_ctrl_mem_write,
                    bus.id_ctrl_mem_to_reg, bus.id_ctrl_alu_src, bus.id_ctrl_reg_write,
                    bus.id_ctrl_alu_op, id_dst};
  assign exmem_d = {bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_reg_write,
                    bus.ex_dst};
  assign memwb_d = {bus.mem_mem_to_reg, bus.mem_reg_write, bus.mem_dst};

  ctrl_stage_reg #(.W(EX_W)) u_idex (
    .clk(clk), .rst(rst), .hold(mem_stall), .bubble(idex_bubble), .d(idex_d), .q(idex_q)
  );
  ctrl_stage_reg #(.W(MEM_W)) u_exmem (
    .clk(clk), .rst(rst), .hold(mem_stall), .bubble(1'b0), .d(exmem_d), .q(exmem_q)
  );
  ctrl_stage_reg #(.W(WB_W)) u_memwb (
    .clk(clk), .rst(rst), .hold(mem_stall), .bubble(1'b0), .d(memwb_d), .q(memwb_q)
  );

  assign {bus.ex_reg_dst, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg,
          bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op, bus.ex_dst} = idex_q;
  assign {bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_to_reg, bus.mem_reg_write,
          bus.mem_dst} = exmem_q;
  assign {bus.wb_mem_to_reg, bus.wb_reg_write, bus.wb_dst} = memwb_q;
  assign bus.mem_timeout = timeout_q;

  // cnt counts stalled cycles of the current access; reaching the limit releases the pipe once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      cnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_req && !bus.mem_ready) begin
            state <= ST_WAIT;
            cnt   <= CNT_W'(1);
          end
        end
        default: begin
          if (bus.mem_ready) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state     <= ST_RUN;
            cnt       <= '0;
            timeout_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Table-driven directed bench for hazard_ctrl_pipe with a hand-written memory-timeout sequence.
module tb_hazard_ctrl_pipe;

  localparam logic [7:0] C_NOP = 8'b0000_0000;
  localparam logic [7:0] C_ADD = 8'b1000_0110;
  localparam logic [7:0] C_LW  = 8'b0101_1100;
  localparam logic [7:0] C_SW  = 8'b0010_1000;
  localparam logic [3:0] M_ADD = 4'b0001;
  localparam logic [3:0] M_LW  = 4'b1011;
  localparam logic [3:0] M_SW  = 4'b0100;
  localparam logic [1:0] W_ADD = 2'b01;
  localparam logic [1:0] W_LW  = 2'b11;
  localparam logic [2:0] HS_RUN  = 3'b011;
  localparam logic [2:0] HS_BUB  = 3'b100;
  localparam logic [2:0] HS_STL  = 3'b000;

  typedef struct {
    logic       rst;
    logic [7:0] ctrl;
    logic [4:0] rs, rt, rd;
    logic       flush, ready;
    logic [2:0] exp_hs;
    logic [7:0] exp_ex;
    logic [4:0] exp_ex_dst;
    logic [3:0] exp_mem;
    logic [4:0] exp_mem_dst;
    logic [1:0] exp_wb;
    logic [4:0] exp_wb_dst;
    logic       exp_to;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   passes;
  vec_t pre_tbl[$];
  vec_t post_tbl[$];

  hazard_ctrl_pipe_if #(.REG_ADDR_W(5), .ALUOP_W(2)) bus ();

  hazard_ctrl_pipe #(.REG_ADDR_W(5), .ALUOP_W(2), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [7:0] c, input int rs, input int rt,
                              input int rd, input logic fl, input logic rdy,
                              input logic [2:0] hs, input logic [7:0] ex, input int exd,
                              input logic [3:0] mw, input int md, input logic [1:0] ww,
                              input int wd, input logic to);
    vec_t v;
    v.rst = r;  v.ctrl = c;  v.rs = 5'(rs);  v.rt = 5'(rt);  v.rd = 5'(rd);
    v.flush = fl;  v.ready = rdy;  v.exp_hs = hs;
    v.exp_ex = ex;  v.exp_ex_dst = 5'(exd);
    v.exp_mem = mw; v.exp_mem_dst = 5'(md);
    v.exp_wb = ww;  v.exp_wb_dst = 5'(wd);
    v.exp_to = to;
    return v;
  endfunction

  task automatic cmp(input string what, input string tag, input int idx,
                     input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s[%0d] %s: got %b required %b", tag, idx, what, got, exp);
    else
      passes++;
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst = v.rst;
    {bus.id_ctrl_reg_dst, bus.id_ctrl_mem_read, bus.id_ctrl_mem_write, bus.id_ctrl_mem_to_reg,
     bus.id_ctrl_alu_src, bus.id_ctrl_reg_write, bus.id_ctrl_alu_op} = v.ctrl;
    bus.id_rs     = v.rs;
    bus.id_rt     = v.rt;
    bus.id_rd     = v.rd;
    bus.flush_id  = v.flush;
    bus.mem_ready = v.ready;
  endtask

  task automatic checkOutput(input vec_t v, input string tag, input int idx);
    #1;
    cmp("re/pc_write/ifid_write", tag, idx, {5'd0, bus.re, bus.pc_write, bus.ifid_write},
        {5'd0, v.exp_hs});
    cmp("ex_ctrl", tag, idx, {bus.ex_reg_dst, bus.ex_mem_read, bus.ex_mem_write,
        bus.ex_mem_to_reg, bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op}, v.exp_ex);
    cmp("ex_dst", tag, idx, {3'd0, bus.ex_dst}, {3'd0, v.exp_ex_dst});
    cmp("mem_ctrl", tag, idx, {4'd0, bus.mem_mem_read, bus.mem_mem_write, bus.mem_mem_to_reg,
        bus.mem_reg_write}, {4'd0, v.exp_mem});
    cmp("mem_dst", tag, idx, {3'd0, bus.mem_dst}, {3'd0, v.exp_mem_dst});
    cmp("wb_ctrl", tag, idx, {6'd0, bus.wb_mem_to_reg, bus.wb_reg_write}, {6'd0, v.exp_wb});
    cmp("wb_dst", tag, idx, {3'd0, bus.wb_dst}, {3'd0, v.exp_wb_dst});
    cmp("mem_timeout", tag, idx, {7'd0, bus.mem_timeout}, {7'd0, v.exp_to});
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    bus.mem_ready = 1'b1;
    bus.flush_id  = 1'b0;
    {bus.id_ctrl_reg_dst, bus.id_ctrl_mem_read, bus.id_ctrl_mem_write, bus.id_ctrl_mem_to_reg,
     bus.id_ctrl_alu_src, bus.id_ctrl_reg_write, bus.id_ctrl_alu_op} = C_NOP;
    bus.id_rs = '0;
    bus.id_rt = '0;
    bus.id_rd = '0;

    // Reset, load-use, r0 immunity, SW wait, flush, flush during stall, rt-side hazard.
    pre_tbl.push_back(mk(1, C_LW , 1, 8, 0, 0, 1, HS_BUB, C_NOP, 0, 0, 0, 0, 0, 0));
    pre_tbl.push_back(mk(1, C_LW , 1, 8, 0, 0, 1, HS_BUB, C_NOP, 0, 0, 0, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_NOP, 0, 0, 0, 0, 1, HS_RUN, C_NOP, 0, 0, 0, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_LW , 1, 8, 0, 0, 1, HS_RUN, C_NOP, 0, 0, 0, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_ADD, 8, 2, 3, 0, 1, HS_BUB, C_LW , 8, 0, 0, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_ADD, 8, 2, 3, 0, 1, HS_RUN, C_NOP, 0, M_LW, 8, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_LW , 0, 0, 0, 0, 1, HS_RUN, C_ADD, 3, 0, 0, W_LW, 8, 0));
    pre_tbl.push_back(mk(0, C_ADD, 0, 0, 5, 0, 1, HS_RUN, C_LW , 0, M_ADD, 3, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_SW , 4, 6, 0, 0, 1, HS_RUN, C_ADD, 5, M_LW, 0, W_ADD, 3, 0));
    pre_tbl.push_back(mk(0, C_ADD, 1, 2, 7, 0, 1, HS_RUN, C_SW , 6, M_ADD, 5, W_LW, 0, 0));
    pre_tbl.push_back(mk(0, C_ADD, 1, 2, 9, 0, 0, HS_STL, C_ADD, 7, M_SW, 6, W_ADD, 5, 0));
    pre_tbl.push_back(mk(0, C_ADD, 1, 2, 9, 0, 0, HS_STL, C_ADD, 7, M_SW, 6, W_ADD, 5, 0));
    pre_tbl.push_back(mk(0, C_ADD, 1, 2, 9, 0, 0, HS_STL, C_ADD, 7, M_SW, 6, W_ADD, 5, 0));
    pre_tbl.push_back(mk(0, C_ADD, 1, 2, 9, 0, 1, HS_RUN, C_ADD, 7, M_SW, 6, W_ADD, 5, 0));
    pre_tbl.push_back(mk(0, C_ADD, 3, 4, 10, 1, 1, HS_RUN, C_ADD, 9, M_ADD, 7, 0, 6, 0));
    pre_tbl.push_back(mk(0, C_LW , 1, 11, 0, 0, 1, HS_RUN, C_NOP, 0, M_ADD, 9, W_ADD, 7, 0));
    pre_tbl.push_back(mk(0, C_ADD, 2, 3, 12, 0, 1, HS_RUN, C_LW , 11, 0, 0, W_ADD, 9, 0));
    pre_tbl.push_back(mk(0, C_ADD, 1, 1, 13, 1, 0, HS_STL, C_ADD, 12, M_LW, 11, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_ADD, 1, 1, 13, 1, 0, HS_STL, C_ADD, 12, M_LW, 11, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_ADD, 1, 1, 13, 1, 1, HS_RUN, C_ADD, 12, M_LW, 11, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_ADD, 5, 6, 14, 0, 1, HS_RUN, C_NOP, 0, M_ADD, 12, W_LW, 11, 0));
    pre_tbl.push_back(mk(0, C_LW , 2, 15, 0, 0, 1, HS_RUN, C_ADD, 14, 0, 0, W_ADD, 12, 0));
    pre_tbl.push_back(mk(0, C_SW , 3, 15, 0, 0, 1, HS_BUB, C_LW , 15, M_ADD, 14, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_SW , 3, 15, 0, 0, 1, HS_RUN, C_NOP, 0, M_LW, 15, W_ADD, 14, 0));
    pre_tbl.push_back(mk(0, C_NOP, 0, 0, 0, 0, 1, HS_RUN, C_SW , 15, 0, 0, W_LW, 15, 0));
    pre_tbl.push_back(mk(0, C_LW , 1, 20, 0, 0, 1, HS_RUN, C_NOP, 0, M_SW, 15, 0, 0, 0));
    pre_tbl.push_back(mk(0, C_LW , 1, 22, 0, 0, 1, HS_RUN, C_LW , 20, 0, 0, 0, 15, 0));

    // After the timeout: sticky flag, then reset in the middle of a stall.
    post_tbl.push_back(mk(0, C_ADD, 22, 0, 21, 0, 1, HS_RUN, C_NOP, 0, M_LW, 22, W_LW, 20, 1));
    post_tbl.push_back(mk(0, C_SW , 0, 1, 0, 0, 1, HS_RUN, C_ADD, 21, 0, 0, W_LW, 22, 1));
    post_tbl.push_back(mk(0, C_NOP, 0, 0, 0, 0, 1, HS_RUN, C_SW , 1, M_ADD, 21, 0, 0, 1));
    post_tbl.push_back(mk(0, C_NOP, 0, 0, 0, 0, 0, HS_STL, C_NOP, 0, M_SW, 1, W_ADD, 21, 1));
    post_tbl.push_back(mk(1, C_NOP, 0, 0, 0, 0, 0, HS_BUB, C_NOP, 0, M_SW, 1, W_ADD, 21, 1));
    post_tbl.push_back(mk(0, C_NOP, 0, 0, 0, 0, 0, HS_RUN, C_NOP, 0, 0, 0, 0, 0, 0));

    foreach (pre_tbl[i]) begin
      applyStimulus(pre_tbl[i]);
      checkOutput(pre_tbl[i], "pre", i);
    end

    // LW with rt=20 sits in MEM and never completes; a dependent ADD on the EX-stage LW
    // waits in ID. 15 stalled cycles, then the release cycle turns into a load-use bubble.
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      v = mk(0, C_ADD, 22, 0, 21, 0, 0, (i < 15) ? HS_STL : HS_BUB,
             C_LW, 22, M_LW, 20, 0, 0, 0);
      applyStimulus(v);
      checkOutput(v, "timeout", i);
    end

    foreach (post_tbl[i]) begin
      applyStimulus(post_tbl[i]);
      checkOutput(post_tbl[i], "post", i);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
